// File: rtl/mem_pkg.sv
// Shared packing offsets for the 65-bit RAM request word and the
// response-routing tag type carried alongside each issued request.
package mem_pkg;

    localparam int ADDR_MSB = 64;
    localparam int ADDR_LSB = 33;
    localparam int WE_BIT   = 32;
    localparam int DATA_MSB = 31;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

// File: rtl/tag_pipe.sv
// LAT-deep tag delay line matching the fixed RAM read latency.
// Ports: CLK, RST_N (async low), tag_in (pushed every cycle), tag_out.
module tag_pipe
    import mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t sr [LAT];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LAT; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign tag_out = sr[LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency RAM.
// Ports: rq_* requests in, mem_* RAM side, rs_* responses out, err sticky.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int LAT = 1,
    parameter int NP  = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NP-1:0]       rq_valid,
    output logic [NP-1:0]       rq_ready,
    input  logic [ADDR_MSB:0]   rq0_get,
    input  logic [ADDR_MSB:0]   rq1_get,
    output logic                mem_rq_en,
    output logic [ADDR_MSB:0]   mem_rq,
    input  logic                mem_rs_en,
    input  logic [DATA_MSB:0]   mem_rs,
    output logic [NP-1:0]       rs_valid,
    output logic [DATA_MSB:0]   rs_data,
    output logic                err
);

    logic          prio;
    logic [NP-1:0] grant;
    tag_t          tag_in;
    tag_t          tag_out;

    // Grant is forced off while reset is held so nothing issues.
    always_comb begin
        grant = '0;
        if (RST_N) begin
            unique case (1'b1)
                (rq_valid == 2'b11): grant = prio ? 2'b10 : 2'b01;
                (rq_valid == 2'b01): grant = 2'b01;
                (rq_valid == 2'b10): grant = 2'b10;
                default:             grant = '0;
            endcase
        end
    end

    assign rq_ready  = grant;
    assign mem_rq_en = |grant;

    always_comb begin
        mem_rq = '0;
        if (grant[1]) begin
            mem_rq = rq1_get;
        end else if (grant[0]) begin
            mem_rq = rq0_get;
        end
    end

    // Bubbles push an invalid tag so the line stays cycle-aligned.
    assign tag_in.valid = |grant;
    assign tag_in.port  = grant[1];

    tag_pipe #(
        .LAT(LAT)
    ) u_tag_pipe (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio <= 1'b0;
        end else if (|grant) begin
            prio <= grant[0];
        end
    end

    always_comb begin
        rs_valid = '0;
        if (tag_out.valid && mem_rs_en) begin
            rs_valid[tag_out.port] = 1'b1;
        end
    end

    assign rs_data = mem_rs;

    // Response and tag must coincide; either one alone is an error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err <= 1'b0;
        end else if (mem_rs_en ^ tag_out.valid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and
// a queue-based reference model of arbitration and response order.
module tb_ram_arbiter;

    localparam int LAT = 1;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [64:0] rq0_get;
    logic [64:0] rq1_get;
    logic        mem_rq_en;
    logic [64:0] mem_rq;
    logic        mem_rs_en;
    logic [31:0] mem_rs;
    logic [1:0]  rs_valid;
    logic [31:0] rs_data;
    logic        err;

    logic spur = 1'b0;
    logic drop = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(
        .LAT(LAT),
        .NP (2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rq_valid (rq_valid),
        .rq_ready (rq_ready),
        .rq0_get  (rq0_get),
        .rq1_get  (rq1_get),
        .mem_rq_en(mem_rq_en),
        .mem_rq   (mem_rq),
        .mem_rs_en(mem_rs_en),
        .mem_rs   (mem_rs),
        .rs_valid (rs_valid),
        .rs_data  (rs_data),
        .err      (err)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return 32'hA5000000 | {16'h0, a, a};
    endfunction

    function automatic logic [64:0] word(input logic [31:0] a,
                                         input logic we,
                                         input logic [31:0] d);
        return {a, we, d};
    endfunction

    // Behavioural RAM: fixed latency, never reset, old data on write.
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];
    logic [31:0]    ram [256];
    logic [255:0]   wr_done = '0;
    logic [7:0]     env_a;

    assign env_a = mem_rq[40:33];

    always @(posedge CLK) begin
        pv[0] <= mem_rq_en;
        pd[0] <= wr_done[env_a] ? ram[env_a] : init_val(env_a);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        if (mem_rq_en && mem_rq[32]) begin
            ram[env_a]     <= mem_rq[31:0];
            wr_done[env_a] <= 1'b1;
        end
    end

    assign mem_rs_en = (pv[LAT-1] & ~drop) | spur;
    assign mem_rs    = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD0BAD;

    typedef struct {
        int          due;
        logic        port;
        logic        wr;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [256];
    logic        prio_m;
    logic        err_m;
    logic [1:0]  last_g;
    logic [1:0]  last_rdy;
    logic [31:0] last_rs0;

    task automatic cyc_run(input logic [1:0] v,
                           input logic [64:0] w0,
                           input logic [64:0] w1);
        logic [1:0]  eg;
        logic [1:0]  ers;
        logic [64:0] gw;
        logic        pend;
        logic        resp;
        logic [7:0]  a;
        exp_t        e;
        rq_valid = v;
        rq0_get  = w0;
        rq1_get  = w1;
        @(negedge CLK);
        pend = (q.size() > 0) && (q[0].due == cyc);
        resp = (pend && !drop) || spur;
        ers  = 2'b00;
        if (pend && resp) ers = q[0].port ? 2'b10 : 2'b01;
        total++;
        if (rs_valid !== ers) begin
            bad++;
            $display("FAIL rs_valid cyc=%0d got=%b want=%b",
                     cyc, rs_valid, ers);
        end
        if (ers != 2'b00 && !q[0].wr) begin
            total++;
            if (rs_data !== q[0].d) begin
                bad++;
                $display("FAIL rs_data cyc=%0d got=%h want=%h",
                         cyc, rs_data, q[0].d);
            end
        end
        if (rs_valid[0]) last_rs0 = rs_data;
        total++;
        if (err !== err_m) begin
            bad++;
            $display("FAIL err cyc=%0d got=%b want=%b", cyc, err, err_m);
        end
        if (v == 2'b11) eg = prio_m ? 2'b10 : 2'b01;
        else eg = v;
        gw = eg[1] ? w1 : (eg[0] ? w0 : 65'h0);
        total++;
        if (rq_ready !== eg) begin
            bad++;
            $display("FAIL rq_ready cyc=%0d got=%b want=%b",
                     cyc, rq_ready, eg);
        end
        total++;
        if (mem_rq_en !== (eg != 2'b00)) begin
            bad++;
            $display("FAIL mem_rq_en cyc=%0d got=%b want=%b",
                     cyc, mem_rq_en, (eg != 2'b00));
        end
        total++;
        if (mem_rq !== gw) begin
            bad++;
            $display("FAIL mem_rq cyc=%0d got=%h want=%h", cyc, mem_rq, gw);
        end
        last_g   = eg;
        last_rdy = rq_ready;
        @(posedge CLK);
        if (pend) void'(q.pop_front());
        if (resp != pend) err_m = 1'b1;
        if (eg != 2'b00) begin
            a      = gw[40:33];
            e.due  = cyc + LAT;
            e.port = eg[1];
            e.wr   = gw[32];
            e.d    = ref_mem[a];
            q.push_back(e);
            if (gw[32]) ref_mem[a] = gw[31:0];
            prio_m = eg[1] ? 1'b0 : 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_run(2'b00, '0, '0);
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        rq_valid = 2'b00;
        spur     = 1'b0;
        drop     = 1'b0;
        repeat (LAT + 1) @(posedge CLK);
        #1 RST_N = 1'b1;
        q.delete();
        prio_m = 1'b0;
        err_m  = 1'b0;
    endtask

    task automatic test_reset();
        RST_N    = 1'b0;
        rq_valid = 2'b11;
        rq0_get  = word(32'h1, 1'b0, 32'h0);
        rq1_get  = word(32'h2, 1'b0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (rq_ready !== 2'b00 || mem_rq_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_issue got=%b/%b want=00/0",
                     rq_ready, mem_rq_en);
        end
        total++;
        if (rs_valid !== 2'b00 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rs got=%b/%b want=00/0", rs_valid, err);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cyc_run(2'b01, word(32'h10, 1'b0, 32'h0), '0);
        total++;
        if (last_rdy !== 2'b01) begin
            bad++;
            $display("FAIL single_ready got=%b want=01", last_rdy);
        end
        idle(LAT + 1);
        total++;
        if (last_rs0 !== init_val(8'h10)) begin
            bad++;
            $display("FAIL single_data got=%h want=%h",
                     last_rs0, init_val(8'h10));
        end
    endtask

    task automatic test_contention();
        logic [1:0] want [4];
        want[0] = 2'b01;
        want[1] = 2'b10;
        want[2] = 2'b01;
        want[3] = 2'b10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc_run(2'b11, word(32'h3 + i, 1'b0, 32'h0),
                    word(32'h8 + i, 1'b0, 32'h0));
            total++;
            if (last_rdy !== want[i]) begin
                bad++;
                $display("FAIL contention_grant%0d got=%b want=%b",
                         i, last_rdy, want[i]);
            end
        end
        idle(LAT + 1);
    endtask

    task automatic test_write_read();
        do_reset();
        cyc_run(2'b10, '0, word(32'h20, 1'b1, 32'hDEADBEEF));
        cyc_run(2'b01, word(32'h20, 1'b0, 32'h0), '0);
        idle(LAT + 1);
        total++;
        if (last_rs0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_read got=%h want=deadbeef", last_rs0);
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        cyc_run(2'b01, word(32'h5, 1'b0, 32'h0), '0);
        idle(1);
        cyc_run(2'b01, word(32'h6, 1'b0, 32'h0), '0);
        idle(LAT + 2);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL bubbles_err got=%b want=0", err);
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = 2'($urandom_range(0, 3));
            cyc_run(v,
                    word($urandom_range(0, 31), 1'($urandom), $urandom),
                    word($urandom_range(0, 31), 1'($urandom), $urandom));
        end
        idle(LAT + 1);
    endtask

    task automatic test_spurious();
        do_reset();
        idle(2);
        spur = 1'b1;
        cyc_run(2'b00, '0, '0);
        spur = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL spurious_err got=%b want=1", err);
        end
        idle(3);
        RST_N = 1'b0;
        #1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL spurious_clear got=%b want=0", err);
        end
        do_reset();
    endtask

    task automatic test_drop();
        do_reset();
        cyc_run(2'b10, '0, word(32'h7, 1'b0, 32'h0));
        idle(LAT - 1);
        drop = 1'b1;
        cyc_run(2'b00, '0, '0);
        drop = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL drop_err got=%b want=1", err);
        end
    endtask

    task automatic test_midflight();
        do_reset();
        cyc_run(2'b01, word(32'h9, 1'b0, 32'h0), '0);
        rq_valid = 2'b11;
        RST_N    = 1'b0;
        #1;
        total++;
        if (rq_ready !== 2'b00 || mem_rq_en !== 1'b0 ||
            rs_valid !== 2'b00 || err !== 1'b0) begin
            bad++;
            $display("FAIL midflight_out got=%b/%b/%b/%b want=00/0/00/0",
                     rq_ready, mem_rq_en, rs_valid, err);
        end
        repeat (LAT + 1) @(posedge CLK);
        #1 RST_N = 1'b1;
        q.delete();
        prio_m = 1'b0;
        err_m  = 1'b0;
        cyc_run(2'b11, word(32'hA, 1'b0, 32'h0), word(32'hB, 1'b0, 32'h0));
        total++;
        if (last_rdy !== 2'b01) begin
            bad++;
            $display("FAIL midflight_prio got=%b want=01", last_rdy);
        end
        idle(LAT + 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        prio_m   = 1'b0;
        err_m    = 1'b0;
        last_rs0 = '0;
        rq_valid = 2'b00;
        rq0_get  = '0;
        rq1_get  = '0;
        RST_N    = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_write_read();
        test_bubbles();
        test_random();
        test_spurious();
        test_drop();
        test_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning fixed RAM read latency in cycles (range 1..4).
REQ-002 SHALL have parameter NP, default 2, meaning number of requester ports (fixed at 2 for this revision).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rq_valid  input  2  per-port request present.
REQ-006 SHALL have port rq_ready  output  2  per-port request accepted this cycle.
REQ-007 SHALL have ports rq0_get and rq1_get  input  65  request word per port, {addr[64:33], iswrite[32], data[31:0]}.
REQ-008 SHALL have port mem_rq_en  output  1  request issued to RAM this cycle.
REQ-009 SHALL have port mem_rq  output  65  forwarded request word, same packing.
REQ-010 SHALL have port mem_rs_en  input  1  RAM response valid; RAM is always ready.
REQ-011 SHALL have port mem_rs  input  32  RAM read data.
REQ-012 SHALL have port rs_valid  output  2  per-port response strobe; requesters are always ready.
REQ-013 SHALL have port rs_data  output  32  response data, shared by both ports.
REQ-014 SHALL have port err  output  1  sticky error flag: response without tag, or tag without response.

Function
REQ-015 SHALL grant at most one port per cycle; grant requires rq_valid of that port; the RAM is always ready.
REQ-016 SHALL use round-robin priority: 1-bit pointer prio names the favoured port; on a grant, prio becomes the other port.
REQ-017 SHALL grant the only valid port regardless of prio when exactly one is valid.
REQ-018 SHALL drive rq_ready[i] combinationally equal to grant[i], and mem_rq_en = |grant, in the same cycle (zero-latency issue).
REQ-019 SHALL drive mem_rq equal to the granted port's word; it is don't-care (drive 0) when mem_rq_en=0.
REQ-020 SHALL push {valid=mem_rq_en, port=granted index} into a LAT-deep tag shift register every cycle, including bubbles.
REQ-021 SHALL issue a write and a read identically; writes also produce a response (RAM returns old/garbage data), and that response SHALL be routed, not dropped.
REQ-022 SHALL assert rs_valid[tag.port] = mem_rs_en combinationally when the tag at the shift-register output is valid; rs_data = mem_rs.
REQ-023 SHALL set err and suppress rs_valid when mem_rs_en=1 and the output tag is invalid; SHALL set err when the output tag is valid and mem_rs_en=0.
REQ-024 SHALL keep err set until reset.
REQ-025 SHALL sustain one issue per cycle under back-to-back requests with responses in issue order.
REQ-026 SHALL route responses in the same cycle that a new grant is made, without interference.

Reset
REQ-027 SHALL asynchronously clear on RST_N=0: prio=0, all tag entries invalid, err=0.
REQ-028 SHALL hold rq_ready=0, mem_rq_en=0, rs_valid=0 while RST_N=0.
REQ-029 SHALL discard in-flight tags on reset mid-operation; stale RAM responses after release SHALL set err only if mem_rs_en arrives with an invalid tag.

Structure
REQ-030 SHALL place the request-word packing offsets (ADDR_MSB=64, ADDR_LSB=33, WE_BIT=32, DATA_MSB=31) and the tag type {valid, port} in a shared package, mem_pkg.
REQ-031 SHALL implement the tag delay line as sub-module tag_pipe (parameter LAT), with all other logic in ram_arbiter.

Verification
REQ-032 SHALL cover single port: port0 reads addr 0x10 once -> rq_ready[0] in the same cycle; rs_valid=2'b01 LAT cycles later with rs_data=RAM[0x10].
REQ-033 SHALL cover contention: both valid for 4 cycles after reset -> grants 0,1,0,1 and responses in order 0,1,0,1.
REQ-034 SHALL cover a write then a read: port1 writes 0xDEADBEEF to 0x20, then port0 reads 0x20 -> port0 receives 0xDEADBEEF; port1 gets a write response strobe.
REQ-035 SHALL cover bubbles: requests on cycles 0 and 2 only -> rs_valid on cycles LAT and LAT+2 only; err stays 0.
REQ-036 SHALL cover a spurious response: mem_rs_en forced with no tag -> err=1, rs_valid=0, err held until RST_N=0.
REQ-037 SHALL cover reset mid-flight: RST_N pulsed low with 1 request outstanding -> all outputs 0 immediately, prio=0 after release.
